// File: rtl/seq_pkg.sv
// Shared definitions for the multicycle sequencer.
// Holds the state encoding, which also appears on the state_o debug port,
// and the default memory-wait timeout.
package seq_pkg;

    localparam int TIMEOUT_DEFAULT = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        DECODE  = 3'd2,
        EXECUTE = 3'd3,
        MEM     = 3'd4,
        WB      = 3'd5,
        HALT    = 3'd6
    } seq_state_e;

endpackage

// File: rtl/multicycle_sequencer_if.sv
// Unified memory port shared by instruction fetch and data access.
//
// Handshake: mem_req_o is the valid. Once raised it stays high, together with
// stable mem_we_o and mem_fetch_o, until the memory answers. mem_ready_i is the
// ready. A request completes in the cycle where mem_req_o and mem_ready_i are
// both 1. mem_ready_i has no effect while mem_req_o is 0.
//
//   mem_req_o    sequencer -> memory  request valid
//   mem_we_o     sequencer -> memory  request is a write
//   mem_fetch_o  sequencer -> memory  request is an instruction fetch
//   mem_ready_i  memory -> sequencer  request completes this cycle
interface multicycle_sequencer_if;
    logic mem_req_o;
    logic mem_we_o;
    logic mem_fetch_o;
    logic mem_ready_i;

    modport master (output mem_req_o, output mem_we_o, output mem_fetch_o,
                    input  mem_ready_i);
    modport slave  (input  mem_req_o, input  mem_we_o, input  mem_fetch_o,
                    output mem_ready_i);
endinterface

// File: rtl/seq_wait_timer.sv
// Memory wait timer.
// Counts cycles spent waiting for the memory and flags when the count reaches
// TIMEOUT-1. The owner qualifies 'expired' with its own waiting condition.
//   clk, reset  clock and asynchronous active-low reset
//   clear       force the count to zero (has priority over enable)
//   enable      count up by one this cycle
//   expired     count equals TIMEOUT-1
module seq_wait_timer #(
    parameter int TIMEOUT = seq_pkg::TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CW'(1);
        end
    end

    assign expired = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/multicycle_sequencer.sv
// Control sequencer for the multicycle RV32I core.
// Steps IDLE -> FETCH -> DECODE -> EXECUTE -> [MEM] -> WB, turns the decoded
// control bits into one-cycle write-enable pulses, arbitrates the single memory
// port between fetch and data access, counts retired instructions, and parks
// in HALT on an illegal opcode, ECALL/EBREAK or a memory timeout.
//   clk, reset                     clock and asynchronous active-low reset
//   start_i, stop_i                leave IDLE / return to IDLE after retiring
//   regwren_i, memren_i, memwren_i decoded write/load/store controls
//   illegal_i, halt_req_i          decoded illegal opcode / ECALL-EBREAK
//   mem_if                         unified memory port (master side)
//   ir_we_o .. pc_we_o             datapath capture/write pulses
//   halt_o, err_o                  halted, and whether it was an error
//   state_o                        current state, for debug
//   instret_o                      retired-instruction count
module multicycle_sequencer
    import seq_pkg::*;
#(
    parameter int DWIDTH  = 32,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic                  stop_i,
    input  logic                  regwren_i,
    input  logic                  memren_i,
    input  logic                  memwren_i,
    input  logic                  illegal_i,
    input  logic                  halt_req_i,
    multicycle_sequencer_if.master mem_if,
    output logic                  ir_we_o,
    output logic                  alu_we_o,
    output logic                  mdr_we_o,
    output logic                  rf_we_o,
    output logic                  pc_we_o,
    output logic                  halt_o,
    output logic                  err_o,
    output logic [2:0]            state_o,
    output logic [DWIDTH-1:0]     instret_o
);

    seq_state_e        state, next_state;
    logic              err_q;
    logic [DWIDTH-1:0] instret_q;
    logic              err_set;
    logic              retire;
    logic              waiting;
    logic              expired;
    logic              mem_req, mem_we, mem_fetch;

    // Timer runs only while a memory request is outstanding; every other
    // state holds it cleared, so it restarts from zero on entry to FETCH/MEM.
    assign waiting = (state == FETCH) || (state == MEM);

    seq_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (!waiting),
        .enable  (waiting && !mem_if.mem_ready_i),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            err_q     <= 1'b0;
            instret_q <= '0;
        end else begin
            state <= next_state;
            if (err_set) begin
                err_q <= 1'b1;
            end
            if (retire) begin
                instret_q <= instret_q + DWIDTH'(1);
            end
        end
    end

    always_comb begin
        next_state = state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_fetch  = 1'b0;
        ir_we_o    = 1'b0;
        alu_we_o   = 1'b0;
        mdr_we_o   = 1'b0;
        rf_we_o    = 1'b0;
        pc_we_o    = 1'b0;
        err_set    = 1'b0;
        retire     = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) next_state = FETCH;
            end
            FETCH: begin
                mem_req   = 1'b1;
                mem_fetch = 1'b1;
                // A ready in the last allowed cycle still completes normally.
                if (mem_if.mem_ready_i) begin
                    ir_we_o    = 1'b1;
                    next_state = DECODE;
                end else if (expired) begin
                    err_set    = 1'b1;
                    next_state = HALT;
                end
            end
            DECODE: begin
                if (illegal_i) begin
                    err_set    = 1'b1;
                    next_state = HALT;
                end else begin
                    next_state = EXECUTE;
                end
            end
            EXECUTE: begin
                alu_we_o   = 1'b1;
                next_state = (memren_i || memwren_i) ? MEM : WB;
            end
            MEM: begin
                mem_req = 1'b1;
                mem_we  = memwren_i;
                if (mem_if.mem_ready_i) begin
                    // Load and store both set is a store: no load data capture.
                    mdr_we_o   = memren_i && !memwren_i;
                    next_state = WB;
                end else if (expired) begin
                    err_set    = 1'b1;
                    next_state = HALT;
                end
            end
            WB: begin
                rf_we_o = regwren_i;
                pc_we_o = 1'b1;
                retire  = 1'b1;
                if (halt_req_i)  next_state = HALT;
                else if (stop_i) next_state = IDLE;
                else             next_state = FETCH;
            end
            HALT: begin
                next_state = HALT;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Request outputs come from the state register, so the asynchronous reset
    // drops mem_req_o at once.
    assign mem_if.mem_req_o   = mem_req;
    assign mem_if.mem_we_o    = mem_we;
    assign mem_if.mem_fetch_o = mem_fetch;
    assign halt_o             = (state == HALT);
    assign err_o              = err_q;
    assign state_o            = state;
    assign instret_o          = instret_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer with an expected-output queue.
module tb_multicycle_sequencer;
    import seq_pkg::*;

    localparam int DWIDTH  = 32;
    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic reset;
    logic start_i, stop_i, regwren_i, memren_i, memwren_i, illegal_i, halt_req_i;
    logic ir_we_o, alu_we_o, mdr_we_o, rf_we_o, pc_we_o, halt_o, err_o;
    logic [2:0]        state_o;
    logic [DWIDTH-1:0] instret_o;

    multicycle_sequencer_if mif();

    multicycle_sequencer #(.DWIDTH(DWIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .start_i    (start_i),
        .stop_i     (stop_i),
        .regwren_i  (regwren_i),
        .memren_i   (memren_i),
        .memwren_i  (memwren_i),
        .illegal_i  (illegal_i),
        .halt_req_i (halt_req_i),
        .mem_if     (mif),
        .ir_we_o    (ir_we_o),
        .alu_we_o   (alu_we_o),
        .mdr_we_o   (mdr_we_o),
        .rf_we_o    (rf_we_o),
        .pc_we_o    (pc_we_o),
        .halt_o     (halt_o),
        .err_o      (err_o),
        .state_o    (state_o),
        .instret_o  (instret_o)
    );

    // Clock / reset
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    logic [12:0]       exp_q[$];
    logic [DWIDTH-1:0] exp_instret;

    // Output vector: {state, req, we, fetch, ir, alu, mdr, rf, pc, halt, err}
    function automatic logic [12:0] ev(input logic [2:0] st, input logic req, we, fe,
                                       ir, alu, mdr, rf, pc, hl, er);
        return {st, req, we, fe, ir, alu, mdr, rf, pc, hl, er};
    endfunction

    function automatic logic [12:0] obs_vec();
        return {state_o, mif.mem_req_o, mif.mem_we_o, mif.mem_fetch_o, ir_we_o,
                alu_we_o, mdr_we_o, rf_we_o, pc_we_o, halt_o, err_o};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: queue the expected outputs, sample at negedge, advance.
    task automatic cyc(input string tag, input logic [12:0] e);
        exp_q.push_back(e);
        @(negedge clk);
        check(tag, 32'(obs_vec()), 32'(exp_q.pop_front()));
        @(posedge clk);
        #1;
    endtask

    // Drive one full instruction starting in FETCH, up to and including WB.
    task automatic run_instr(input string name, input logic rwe, ren, wen, hreq, stp,
                             input int fwait, input int mwait);
        regwren_i = rwe; memren_i = ren; memwren_i = wen;
        halt_req_i = hreq; stop_i = stp; illegal_i = 1'b0;
        for (int i = 0; i < fwait; i++) begin
            mif.mem_ready_i = 1'b0;
            cyc({name, "_fwait"}, ev(FETCH, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        end
        mif.mem_ready_i = 1'b1;
        cyc({name, "_fetch"}, ev(FETCH, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        mif.mem_ready_i = 1'($urandom_range(0, 1));
        cyc({name, "_decode"}, ev(DECODE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        mif.mem_ready_i = 1'($urandom_range(0, 1));
        cyc({name, "_execute"}, ev(EXECUTE, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        if (ren || wen) begin
            for (int i = 0; i < mwait; i++) begin
                mif.mem_ready_i = 1'b0;
                cyc({name, "_mwait"}, ev(MEM, 1, wen, 0, 0, 0, 0, 0, 0, 0, 0));
            end
            mif.mem_ready_i = 1'b1;
            cyc({name, "_mem"}, ev(MEM, 1, wen, 0, 0, 0, ren && !wen, 0, 0, 0, 0));
        end
        mif.mem_ready_i = 1'($urandom_range(0, 1));
        cyc({name, "_wb"}, ev(WB, 0, 0, 0, 0, 0, 0, rwe, 1, 0, 0));
        exp_instret = exp_instret + 1;
        check({name, "_instret"}, instret_o, exp_instret);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        start_i = 0; stop_i = 0; regwren_i = 0; memren_i = 0; memwren_i = 0;
        illegal_i = 0; halt_req_i = 0; mif.mem_ready_i = 0;
        exp_instret = '0;
        @(posedge clk);
        #1;
        check("rst_vec", 32'(obs_vec()), 32'(ev(IDLE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        check("rst_instret", instret_o, exp_instret);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        start_i = 0; stop_i = 0; regwren_i = 0; memren_i = 0; memwren_i = 0;
        illegal_i = 0; halt_req_i = 0; mif.mem_ready_i = 0;
        exp_instret = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_vec", 32'(obs_vec()), 32'(ev(IDLE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        check("reset_instret", instret_o, exp_instret);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Zero-wait ADD; start_i held high to show it is ignored outside IDLE.
        start_i = 1'b1;
        mif.mem_ready_i = 1'b1;
        cyc("idle_start", ev(IDLE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        run_instr("add", 1, 0, 0, 0, 0, 0, 0);
        start_i = 1'b0;
        run_instr("load_w3", 1, 1, 0, 0, 0, 0, 3);
        run_instr("store", 0, 0, 1, 0, 0, 0, 0);
        run_instr("ld_st_both", 1, 1, 1, 0, 0, 1, 2);
        run_instr("fetch_edge", 1, 0, 0, 0, 0, TIMEOUT - 1, 0);
        run_instr("mem_edge", 1, 1, 0, 0, 0, 0, TIMEOUT - 1);
        run_instr("stop", 1, 0, 0, 0, 1, 2, 0);

        // Back in IDLE: ready is ignored, no start means stay.
        stop_i = 1'b0;
        mif.mem_ready_i = 1'b1;
        cyc("idle_hold", ev(IDLE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        start_i = 1'b1;
        cyc("idle_restart", ev(IDLE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        start_i = 1'b0;

        // Fetch never answered: timeout halt with error.
        mif.mem_ready_i = 1'b0;
        for (int i = 0; i < TIMEOUT; i++) begin
            cyc("fetch_to_wait", ev(FETCH, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        end
        start_i = 1'b1;
        mif.mem_ready_i = 1'b1;
        cyc("halt_fetch_to", ev(HALT, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        cyc("halt_sticky", ev(HALT, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        check("halt_fetch_to_instret", instret_o, exp_instret);

        // Illegal opcode in DECODE.
        do_reset();
        start_i = 1'b1;
        mif.mem_ready_i = 1'b1;
        cyc("ill_idle", ev(IDLE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        start_i = 1'b0;
        illegal_i = 1'b1;
        regwren_i = 1'b1;
        cyc("ill_fetch", ev(FETCH, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        cyc("ill_decode", ev(DECODE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc("ill_halt", ev(HALT, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        check("ill_instret", instret_o, exp_instret);

        // ECALL with stop_i also set: halt wins, no error, instruction retires.
        do_reset();
        start_i = 1'b1;
        cyc("ecall_idle", ev(IDLE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        start_i = 1'b0;
        run_instr("ecall", 1, 0, 0, 1, 1, 0, 0);
        cyc("ecall_halt", ev(HALT, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));

        // Data access never answered: timeout halt from MEM.
        do_reset();
        start_i = 1'b1;
        cyc("memto_idle", ev(IDLE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        start_i = 1'b0;
        regwren_i = 1'b0; memren_i = 1'b0; memwren_i = 1'b1;
        mif.mem_ready_i = 1'b1;
        cyc("memto_fetch", ev(FETCH, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        cyc("memto_decode", ev(DECODE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc("memto_execute", ev(EXECUTE, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        mif.mem_ready_i = 1'b0;
        for (int i = 0; i < TIMEOUT; i++) begin
            cyc("memto_wait", ev(MEM, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        end
        cyc("memto_halt", ev(HALT, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));

        // Reset in the middle of a MEM wait.
        do_reset();
        start_i = 1'b1;
        cyc("mrst_idle", ev(IDLE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        start_i = 1'b0;
        run_instr("mrst_add", 1, 0, 0, 0, 0, 0, 0);
        regwren_i = 1'b1; memren_i = 1'b1; memwren_i = 1'b0;
        mif.mem_ready_i = 1'b1;
        cyc("mrst_fetch", ev(FETCH, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        cyc("mrst_decode", ev(DECODE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc("mrst_execute", ev(EXECUTE, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        mif.mem_ready_i = 1'b0;
        cyc("mrst_wait", ev(MEM, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc("mrst_wait", ev(MEM, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        check("mrst_req_before", 32'(mif.mem_req_o), 32'(1));
        #1;
        reset = 1'b0;
        #1;
        check("mrst_req_async", 32'(mif.mem_req_o), 32'(0));
        check("mrst_state_async", 32'(state_o), 32'(IDLE));
        @(negedge clk);
        reset = 1'b1;
        exp_instret = '0;
        @(posedge clk);
        #1;
        check("mrst_after_vec", 32'(obs_vec()), 32'(ev(IDLE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        check("mrst_after_instret", instret_o, exp_instret);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- FSM that sequences the multicycle RV32I core through FETCH, DECODE, EXECUTE, MEM and WB.
- Gates the decoded control bits (regwren, memren, memwren) into per-state write-enable pulses.
- Shares the single unified memory port between instruction fetch and data access.
- Sits between the decode-stage control unit and the datapath/memory interface.
- Counts retired instructions and halts on illegal instructions, explicit halt requests, or memory timeout.

Parameters:
- DWIDTH, 32, data width; also the width of instret_o.
- TIMEOUT, 16, max cycles waiting for mem_ready_i in FETCH or MEM before an error halt; must be ≥2.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-low reset
- start_i  in  1  leave IDLE and begin fetching
- stop_i  in  1  return to IDLE after the current instruction retires
- regwren_i  in  1  decoded register write enable
- memren_i  in  1  decoded load
- memwren_i  in  1  decoded store
- illegal_i  in  1  decoded opcode unsupported
- halt_req_i  in  1  decoded ECALL/EBREAK
- mem_ready_i  in  1  memory completes the current request this cycle
- mem_req_o  out  1  memory request valid
- mem_we_o  out  1  request is a write
- mem_fetch_o  out  1  request is an instruction fetch
- ir_we_o  out  1  capture the instruction register
- alu_we_o  out  1  capture the ALU result register
- mdr_we_o  out  1  capture load data
- rf_we_o  out  1  register file write
- pc_we_o  out  1  PC update
- halt_o  out  1  sequencer halted
- err_o  out  1  halt was caused by an error
- state_o  out  3  current state encoding, for debug
- instret_o  out  DWIDTH  retired-instruction count

Behaviour:
- Reset value of every output: state IDLE, all pulse and request outputs 0, halt_o=0, err_o=0, instret_o=0.
  - Assertion of reset drops mem_req_o immediately, without waiting for a clock edge, even mid-transaction.
- Moore outputs are a function of state only. Mealy pulses (ir_we_o, mdr_we_o) may also depend on mem_ready_i.
- IDLE: no request. start_i=1 → FETCH on the next edge.
- FETCH:
  - mem_req_o=1, mem_fetch_o=1, mem_we_o=0, held until mem_ready_i=1.
  - In the mem_ready_i cycle: ir_we_o=1, next state DECODE.
  - Minimum FETCH latency is 1 cycle.
- DECODE: one cycle.
  - illegal_i=1 → HALT with err_o=1.
  - Otherwise → EXECUTE.
- EXECUTE: one cycle, alu_we_o=1.
  - memren_i or memwren_i → MEM; otherwise → WB.
- MEM:
  - mem_req_o=1, mem_fetch_o=0, mem_we_o=memwren_i, held until mem_ready_i=1.
  - In the mem_ready_i cycle: mdr_we_o=memren_i, next state WB.
  - memren_i and memwren_i both set is treated as a store.
- WB: one cycle.
  - rf_we_o=regwren_i, pc_we_o=1, instret_o increments by 1 (wraps modulo 2^DWIDTH).
  - Next-state priority: halt_req_i → HALT (err_o=0); else stop_i → IDLE; else → FETCH.
- HALT: terminal.
  - halt_o=1; err_o holds its cause.
  - No requests or pulses; only reset exits.
- Wait timer:
  - Cleared on entry to FETCH or MEM; increments each cycle without mem_ready_i.
  - When it reaches TIMEOUT-1 with mem_ready_i still 0 → HALT with err_o=1.
  - mem_ready_i in the same cycle as TIMEOUT-1 wins: normal completion.
- Boundary conditions:
  - mem_ready_i outside FETCH/MEM is ignored.
  - start_i outside IDLE is ignored.
  - stop_i is sampled only in WB.
- Inputs regwren_i, memren_i, memwren_i, illegal_i and halt_req_i are decoded from the IR. They are assumed stable from DECODE through WB.
- Per-instruction cycle count: 4 + fetch wait + mem wait for non-memory ops; 5 + waits for loads and stores.

Decomposition:
- Package seq_pkg holds:
  - enum seq_state_e: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WB=5, HALT=6;
  - default TIMEOUT constant.
- Sub-module seq_wait_timer: clear/enable counter that outputs an expired flag; one instance.

Test Plan:
- R-type ADD, zero-wait memory, start_i pulsed once:
  - states 0→1→2→3→5→1;
  - ir_we_o in cycle 1; alu_we_o in cycle 3; rf_we_o and pc_we_o in cycle 4;
  - instret_o=1 after 5 cycles.
- Load with mem_ready_i delayed 3 cycles in MEM:
  - mem_req_o=1, mem_we_o=0 for 4 cycles;
  - mdr_we_o pulses only in the ready cycle; then rf_we_o=1.
- Store (memwren_i=1, regwren_i=0): mem_we_o=1 in MEM; rf_we_o stays 0; pc_we_o=1.
- Timeout boundary with TIMEOUT=16:
  - mem_ready_i arriving on the 16th FETCH cycle completes normally;
  - mem_ready_i never arriving → HALT, halt_o=1, err_o=1, mem_req_o=0.
- Exceptional decodes:
  - illegal_i=1 in DECODE → HALT with err_o=1, no rf_we_o;
  - halt_req_i=1 together with stop_i=1 in WB → HALT with err_o=0, instret_o incremented.
- Reset asserted mid-MEM wait: mem_req_o=0 before the next clk edge; after release, state IDLE and instret_o=0.
